smm_tile_sequencer: RTL and testbench
=====================================

# smm_tile_sequencer

Upstream/downstream sequencer for the 4x4 Strassen tile multiplier (SMM1). It accepts a word-serial stream of A and B elements, packs them into the multiplier's row-major operand buses, and pulses `load`. It then waits a fixed pipeline latency, captures the 4x4 result bus, and streams the result back out word-serially. Only one job is in flight at a time.

## Interface

Parameters:
- `DATAWIDTH`, 32: element width in bits.
- `BUSWIDTH`, DATAWIDTH*16: packed 4x4 tile width.
- `RESULT_LATENCY`, 6: cycles from the rising edge that asserts `load` to the edge where `c_in` is valid; legal range 1..255.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: input element valid.
- `in_ready`, out, 1: sequencer accepts an element.
- `in_data`, in, DATAWIDTH: signed element.
- `sel_mode`, in, 1: multiplier mode; sampled with the first A element of a job.
- `a_bus`, out, BUSWIDTH: packed A tile to the multiplier.
- `b_bus`, out, BUSWIDTH: packed B tile to the multiplier.
- `load`, out, 1: one-cycle start pulse to the multiplier.
- `sel`, out, 1: mode to the multiplier; stable for the whole job.
- `c_in`, in, BUSWIDTH: multiplier result bus (`C_out`).
- `out_valid`, out, 1: result element valid.
- `out_ready`, in, 1: consumer accepts an element.
- `out_data`, out, DATAWIDTH: result element.
- `out_last`, out, 1: marks the 16th result element.
- `busy`, out, 1: high in every state except LOAD_A with count 0.

## Operation

Packing:
- Element (r,c) occupies lane r*4+c, bits [(r*4+c)*DATAWIDTH +: DATAWIDTH].
- Elements arrive and leave row-major: lane 0 first, lane 15 last.

Input stream:
- Carries 16 A elements, then 16 B elements.
- An element transfers on any edge with `in_valid && in_ready`.

States:
- LOAD_A (reset state):
  - `in_ready`=1.
  - Each transfer writes `a_bus` lane `cnt` and increments `cnt`.
  - The first transfer (`cnt`=0) also latches `sel_mode` into `sel`.
  - The transfer with `cnt`=15 goes to LOAD_B with `cnt`=0.
- LOAD_B:
  - Same as LOAD_A, but writes `b_bus`.
  - The transfer with `cnt`=15 goes to FIRE.
- FIRE:
  - `in_ready`=0; `load`=1 for exactly this cycle.
  - Loads the latency counter with RESULT_LATENCY-1, then goes to WAIT.
- WAIT:
  - Decrements the counter each cycle.
  - When the counter is 0, registers `c_in` into the result buffer and goes to DRAIN with `cnt`=0.
- DRAIN:
  - `out_valid`=1; `out_data` = buffer lane `cnt`; `out_last` = (`cnt`==15).
  - `cnt` advances on each `out_valid && out_ready`.
  - The transfer of lane 15 returns to LOAD_A with `cnt`=0.

Holding rules:
- `a_bus`, `b_bus` and `sel` hold their values from FIRE until the next job's first transfer, because the multiplier samples combinationally after `load`.
- `sel` changes only on the first A transfer of a job.

Arithmetic:
- No arithmetic on data; lanes are copied bit-exact.
- `cnt` is 4 bits and wraps only through the state transitions above.

## Timing

- Reset values: `in_ready`=1, `load`=0, `sel`=0, `a_bus`=0, `b_bus`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0. State is LOAD_A, `cnt`=0, result buffer 0.
- Reset asserted mid-job (any state): everything above returns to reset values on that edge. No `load` pulse and no `out_valid` occur after that edge until a new full job completes.
- Outputs are registered, except:
  - `in_ready`, which is decoded from the state register;
  - `out_data`/`out_last`, which are a mux of registered state.
- `load` rises on the edge after the 32nd input transfer.
- Capture happens exactly RESULT_LATENCY edges after the edge that raised `load`.
- `out_valid` rises on the following edge.
- Minimum job length with continuous valid/ready: 32 + 1 + RESULT_LATENCY + 16 cycles.
- `out_valid` is held with stable data while `out_ready`=0.
- `in_valid` is ignored outside LOAD_A/LOAD_B.

## Configuration

- `SMM_TILE_SEQUENCER_PERF_EN` defined:
  - Adds output `job_cycles` [15:0].
  - A counter clears on the first A transfer and increments every cycle until the last-lane output transfer; it saturates at 0xFFFF.
  - `job_cycles` updates on that last transfer and resets to 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Structure

- Shared package `smm_pkg` holds:
  - the state enum (LOAD_A, LOAD_B, FIRE, WAIT, DRAIN);
  - the `TILE_DIM`=4 and `TILE_ELEMS`=16 constants;
  - a lane-offset function, lane*DATAWIDTH.
- One sub-module, `smm_tile_unpacker`: the DRAIN-side result buffer plus lane mux with its valid/ready/last logic.
- The FSM, packing and latency counter stay in the top.

## Test plan

- Identity x B:
  - Stimulus: A=I, B elements 1..16, `sel_mode`=0, with a behavioural multiplier stub of latency RESULT_LATENCY.
  - Required: `load` pulses once, `a_bus` lane 0 = 1, outputs are 1..16, `out_last` only on 16.
- Latency check:
  - Stimulus: RESULT_LATENCY=6; stub drives `c_in`=0xDEAD only on the 6th edge after `load`.
  - Required: output lane 0 = 0xDEAD.
- Backpressure on both streams:
  - Stimulus: `in_valid` toggles 1/0; `out_ready` pattern 1,0,0,1.
  - Required: data is unchanged while stalled; 16 outputs with exact ordering.
- Mode latching:
  - Stimulus: `sel_mode`=1 at the first A element, then 0 for the rest of the job.
  - Required: `sel`=1 until the next job's first element; two back-to-back jobs give `sel` 1 then 0.
- Reset mid-job:
  - Stimulus: assert `rst` in WAIT, then run a fresh job.
  - Required: no output from the aborted job; the fresh job's results are correct; `busy`=0 after reset.
- With `SMM_TILE_SEQUENCER_PERF_EN` and continuous handshakes, RESULT_LATENCY=6:
  - Required: `job_cycles`=55.

Source files
------------

// File: rtl/smm_pkg.sv
// Shared types and constants for the SMM tile sequencer slice.
package smm_pkg;

    localparam int unsigned TILE_DIM   = 4;
    localparam int unsigned TILE_ELEMS = TILE_DIM * TILE_DIM;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LAT_W      = 8;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        FIRE,
        WAIT,
        DRAIN
    } state_t;

    // Bit offset of a row-major lane inside a packed tile bus.
    function automatic int unsigned lane_offset(input logic [CNT_W-1:0] lane,
                                                input int unsigned dw);
        return 32'(lane) * dw;
    endfunction

endpackage

// File: rtl/smm_tile_unpacker.sv
// Result buffer for one 4x4 tile, streamed out row-major with valid/ready.
module smm_tile_unpacker
    import smm_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned BUSWIDTH  = DATAWIDTH * 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [BUSWIDTH-1:0]  c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 done_c
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(TILE_ELEMS - 1);

    logic [BUSWIDTH-1:0] res_q;
    logic [CNT_W-1:0]    rd_cnt_q;
    logic                valid_q;

    assign done_c    = valid_q && out_ready && (rd_cnt_q == LAST_LANE);
    assign out_valid = valid_q;
    assign out_data  = valid_q ? res_q[lane_offset(rd_cnt_q, DATAWIDTH) +: DATAWIDTH]
                               : '0;
    assign out_last  = valid_q && (rd_cnt_q == LAST_LANE);

    // Counter rolls 15 -> 0 on the final transfer, ready for the next tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q    <= '0;
            rd_cnt_q <= '0;
            valid_q  <= 1'b0;
        end else if (capture) begin
            res_q    <= c_in;
            rd_cnt_q <= '0;
            valid_q  <= 1'b1;
        end else if (valid_q && out_ready) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            if (rd_cnt_q == LAST_LANE) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/smm_tile_sequencer.sv
// Packs A/B element streams for the 4x4 tile multiplier, fires it and drains C.
// Optional macro SMM_TILE_SEQUENCER_PERF_EN adds the job_cycles counter output.
module smm_tile_sequencer
    import smm_pkg::*;
#(
    parameter int unsigned DATAWIDTH      = 32,
    parameter int unsigned BUSWIDTH       = DATAWIDTH * 16,
    parameter int unsigned RESULT_LATENCY = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 sel_mode,
    output logic [BUSWIDTH-1:0]  a_bus,
    output logic [BUSWIDTH-1:0]  b_bus,
    output logic                 load,
    output logic                 sel,
    input  logic [BUSWIDTH-1:0]  c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
`ifdef SMM_TILE_SEQUENCER_PERF_EN
    ,
    output logic [15:0]          job_cycles
`endif
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(TILE_ELEMS - 1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(RESULT_LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             a_we, b_we, first_xfer, capture, drain_done_c;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            lat_q   <= '0;
            load    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            load    <= (state_d == FIRE);
            busy    <= !((state_d == LOAD_A) && (cnt_d == '0));
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        a_we       = 1'b0;
        b_we       = 1'b0;
        first_xfer = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            LOAD_A: begin
                if (in_valid) begin
                    a_we       = 1'b1;
                    first_xfer = (cnt_q == '0);
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_LANE) begin
                        state_d = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    b_we  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_LANE) begin
                        state_d = FIRE;
                    end
                end
            end
            FIRE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_done_c) begin
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = LOAD_A;
            end
        endcase
    end

    // Operand buses and mode persist past FIRE: the multiplier reads them after load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_bus <= '0;
            b_bus <= '0;
            sel   <= 1'b0;
        end else begin
            if (a_we) begin
                a_bus[lane_offset(cnt_q, DATAWIDTH) +: DATAWIDTH] <= in_data;
            end
            if (b_we) begin
                b_bus[lane_offset(cnt_q, DATAWIDTH) +: DATAWIDTH] <= in_data;
            end
            if (first_xfer) begin
                sel <= sel_mode;
            end
        end
    end

    smm_tile_unpacker #(
        .DATAWIDTH (DATAWIDTH),
        .BUSWIDTH  (BUSWIDTH)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done_c    (drain_done_c)
    );

`ifdef SMM_TILE_SEQUENCER_PERF_EN
    logic [15:0] perf_q;

    // Counts inclusive cycles from the first A transfer to the last C transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q     <= '0;
            job_cycles <= '0;
        end else begin
            if (first_xfer) begin
                perf_q <= 16'd1;
            end else if (perf_q != 16'hFFFF) begin
                perf_q <= perf_q + 16'd1;
            end
            if (drain_done_c) begin
                job_cycles <= (perf_q == 16'hFFFF) ? 16'hFFFF : perf_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_smm_tile_sequencer.sv
// Directed table-driven bench for smm_tile_sequencer with a behavioural multiplier stub.
module tb_smm_tile_sequencer;

    localparam int DW = 32;
    localparam int BW = DW * 16;
    localparam int RL = 6;

    typedef struct packed {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] c;
        logic          sel_mode;
        logic          in_stall;
        logic          out_stall;
        logic          dead;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          sel_mode;
    logic [BW-1:0] a_bus;
    logic [BW-1:0] b_bus;
    logic          load;
    logic          sel;
    logic [BW-1:0] c_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef SMM_TILE_SEQUENCER_PERF_EN
    logic [15:0]   job_cycles;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   load_cnt = 0;
    logic stub_dead = 1'b0;
    vec_t vecs[4];
    vec_t dv;

    smm_tile_sequencer #(
        .DATAWIDTH      (DW),
        .BUSWIDTH       (BW),
        .RESULT_LATENCY (RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel_mode  (sel_mode),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .load      (load),
        .sel       (sel),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SMM_TILE_SEQUENCER_PERF_EN
        ,
        .job_cycles(job_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load) load_cnt++;

    function automatic logic [BW-1:0] matmul(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] c;
        logic signed [DW-1:0] s;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                s = '0;
                for (int k = 0; k < 4; k++) begin
                    s = s + $signed(a[(r*4+k)*DW +: DW]) * $signed(b[(k*4+col)*DW +: DW]);
                end
                c[(r*4+col)*DW +: DW] = s;
            end
        end
        return c;
    endfunction

    // Multiplier stub: sees load in the FIRE cycle, drives C for exactly one cycle RL edges later.
    initial begin
        logic [BW-1:0] prod;
        c_in = '0;
        forever begin
            @(negedge clk);
            if (load) begin
                prod = stub_dead ? BW'(32'hDEAD) : matmul(a_bus, b_bus);
                repeat (RL) @(posedge clk);
                #1 c_in = prod;
                @(posedge clk);
                #1 c_in = '0;
            end
        end
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_inputs(input vec_t v);
        int t;
        for (int i = 0; i < 32; i++) begin
            if (v.in_stall && (i % 2 == 1)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 32'hBAD0_0000 | 32'(i);
                sel_mode = v.sel_mode;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (i < 16) ? v.a[i*DW +: DW] : v.b[(i-16)*DW +: DW];
            sel_mode = (i == 0) ? v.sel_mode : !v.sel_mode;
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk("in_ready_timeout", BW'(in_ready), BW'(1));
        end
        @(negedge clk);
        in_valid = v.in_stall;
        in_data  = 32'hFFFF_FFFF;
        chk("load_in_fire", BW'(load), BW'(1));
        chk("in_ready_fire", BW'(in_ready), BW'(0));
        chk("busy_fire", BW'(busy), BW'(1));
        chk("sel_fire", BW'(sel), BW'(v.sel_mode));
        chk("a_lane0", BW'(a_bus[DW-1:0]), BW'(v.a[DW-1:0]));
        chk("a_bus", a_bus, v.a);
        chk("b_bus", b_bus, v.b);
    endtask

    task automatic drain_outputs(input vec_t v);
        int  idx  = 0;
        int  cyc  = 0;
        bit  seen = 0;
        while (idx < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            out_ready = !(v.out_stall && ((cyc % 4 == 1) || (cyc % 4 == 2)));
            if (out_valid) begin
                if (!seen) begin
                    seen     = 1;
                    in_valid = 1'b0;
                    chk("first_valid_latency", BW'(cyc), BW'(RL + 1));
                end
                chk($sformatf("out_data[%0d]", idx), BW'(out_data), BW'(v.c[idx*DW +: DW]));
                chk($sformatf("out_last[%0d]", idx), BW'(out_last), BW'(idx == 15));
                if (out_ready) idx++;
            end
        end
        if (idx < 16) chk("drain_timeout", BW'(idx), BW'(16));
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after", BW'(out_valid), BW'(0));
        chk("busy_after", BW'(busy), BW'(0));
        chk("in_ready_after", BW'(in_ready), BW'(1));
        chk("sel_hold", BW'(sel), BW'(v.sel_mode));
        chk("b_bus_hold", b_bus, v.b);
        chk("load_pulses", BW'(load_cnt), BW'(1));
`ifdef SMM_TILE_SEQUENCER_PERF_EN
        if (!v.in_stall && !v.out_stall) chk("job_cycles", BW'(job_cycles), BW'(32 + 1 + RL + 16));
`endif
    endtask

    task automatic run_job(input vec_t v);
        load_cnt  = 0;
        stub_dead = v.dead;
        send_inputs(v);
        drain_outputs(v);
    endtask

    initial begin
        int ov_cnt;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel_mode = 1'b0; out_ready = 1'b0;

        for (int k = 0; k < 4; k++) vecs[k] = '0;
        for (int i = 0; i < 16; i++) begin
            vecs[0].a[i*DW +: DW] = (i % 5 == 0) ? 32'd1 : 32'd0;
            vecs[0].b[i*DW +: DW] = 32'(i + 1);
            vecs[0].c[i*DW +: DW] = 32'(i + 1);
            vecs[1].a[i*DW +: DW] = (i % 5 == 0) ? 32'd2 : 32'd0;
            vecs[1].b[i*DW +: DW] = 32'(i + 1);
            vecs[1].c[i*DW +: DW] = 32'(2 * (i + 1));
            vecs[2].a[i*DW +: DW] = 32'(i + 1);
            vecs[2].b[i*DW +: DW] = 32'd1;
            vecs[2].c[i*DW +: DW] = 32'(16 * (i / 4) + 10);
            vecs[3].a[i*DW +: DW] = (i % 5 == 0) ? 32'hFFFF_FFFF : 32'd0;
            vecs[3].b[i*DW +: DW] = 32'(i + 1);
            vecs[3].c[i*DW +: DW] = 32'(-(i + 1));
        end
        vecs[1].sel_mode = 1'b1; vecs[1].in_stall = 1'b1; vecs[1].out_stall = 1'b1;
        vecs[2].out_stall = 1'b1;
        vecs[3].sel_mode = 1'b1; vecs[3].in_stall = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        chk("rst_load", BW'(load), BW'(0));
        chk("rst_sel", BW'(sel), BW'(0));
        chk("rst_a_bus", a_bus, '0);
        chk("rst_b_bus", b_bus, '0);
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_out_data", BW'(out_data), BW'(0));
        chk("rst_out_last", BW'(out_last), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        rst = 1'b0;

        for (int k = 0; k < 4; k++) run_job(vecs[k]);

        // Latency window: C is valid for a single cycle only.
        dv = vecs[0];
        dv.dead = 1'b1;
        dv.c = BW'(32'hDEAD);
        run_job(dv);

        // Abort a job while waiting on the multiplier, then run a clean one.
        load_cnt = 0;
        stub_dead = 1'b0;
        send_inputs(vecs[0]);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", BW'(busy), BW'(0));
        chk("abort_in_ready", BW'(in_ready), BW'(1));
        chk("abort_load", BW'(load), BW'(0));
        chk("abort_a_bus", a_bus, '0);
        chk("abort_sel", BW'(sel), BW'(0));
        load_cnt = 0;
        ov_cnt = 0;
        repeat (RL + 20) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_out_valid", BW'(ov_cnt), BW'(0));
        chk("abort_no_load", BW'(load_cnt), BW'(0));
        run_job(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
